// File: rtl/key_event_decoder.sv
// key_event_decoder: turns live CMD/KEY button levels into debounced press events.
// Optional KEY_AUTOREPEAT_EN macro adds hold-to-repeat on the KEY group.
//
// Ports:
//   CLK, RST_N        clock, async active-low reset
//   MODE              1 = CMD group live, 0 = KEY group live
//   CMD_Reg, KEY_Reg  raw 4-bit key levels
//   EVT_VALID/READY   event FIFO handshake (first-word fall-through)
//   EVT_IS_CMD        head event came from the CMD group
//   EVT_CODE          head event key index
//   EVT_OVF           sticky drop flag, cleared by CLR_OVF
module key_event_decoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int FIFO_DEPTH      = 4
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       MODE,
  input  logic [3:0] CMD_Reg,
  input  logic [3:0] KEY_Reg,
  output logic       EVT_VALID,
  input  logic       EVT_READY,
  output logic       EVT_IS_CMD,
  output logic [1:0] EVT_CODE,
  output logic       EVT_OVF,
  input  logic       CLR_OVF
);

  localparam logic REL = (KEY_ACTIVE_LOW != 0);
  localparam int   AW  = $clog2(FIFO_DEPTH);

  // bits 7:4 = CMD group, bits 3:0 = KEY group
  logic [7:0]       s1, s2, stable;
  logic [CNT_W-1:0] cnt [8];
  logic             mode_s1, mode_s2, mode_q;
  logic [7:0]       prs, prev_prs;
  logic [7:0]       armed, pend;
  logic [7:0]       live, new_press, rep_set, pop_mask;
  logic             mode_edge;
  logic             push, pop, wr, full;
  logic             sel_cmd;
  logic [1:0]       sel_code;
  logic [2:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      occ;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1      <= {8{REL}};
      s2      <= {8{REL}};
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      s1      <= {CMD_Reg, KEY_Reg};
      s2      <= s1;
      mode_s1 <= MODE;
      mode_s2 <= mode_s1;
      mode_q  <= mode_s2;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stable <= {8{REL}};
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (s2[i] != stable[i]) begin
          if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable[i] <= s2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign prs       = stable ^ {8{REL}};
  assign mode_edge = mode_s2 ^ mode_q;
  assign live      = mode_s2 ? 8'hF0 : 8'h0F;
  assign new_press = prs & ~prev_prs & armed & live;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [3:0]    hold, owner;
  logic          rel_any, restart, rep_hit, rep_first;
  logic [RW-1:0] rep_cnt;

  assign hold    = prs[3:0] & armed[3:0] & {4{~mode_s2}};
  assign owner   = hold & (~hold + 4'd1);
  assign rel_any = |(~prs & prev_prs);
  assign restart = mode_edge | rel_any | (hold == 4'd0);
  assign rep_hit = !restart &&
                   (rep_first ? (rep_cnt == RW'(REPEAT_DELAY - 1))
                              : (rep_cnt == RW'(REPEAT_PERIOD - 1)));
  assign rep_set = {4'd0, rep_hit ? owner : 4'd0};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (restart) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_hit) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_set = 8'd0;
`endif

  // lowest pending index wins, CMD group over KEY group
  always_comb begin
    sel_cmd  = 1'b0;
    sel_code = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) begin
        sel_cmd  = 1'b0;
        sel_code = 2'(i);
      end
    end
    for (int i = 3; i >= 0; i--) begin
      if (pend[i+4]) begin
        sel_cmd  = 1'b1;
        sel_code = 2'(i);
      end
    end
    pop_mask = 8'd1 << {sel_cmd, sel_code};
  end

  assign push = |pend;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_prs <= 8'd0;
      armed    <= 8'hFF;
      pend     <= 8'd0;
    end else begin
      prev_prs <= prs;
      if (mode_edge) begin
        armed <= 8'd0;
        pend  <= 8'd0;
      end else begin
        armed <= armed | ~prs;
        pend  <= (pend & ~pop_mask) | new_press | rep_set;
      end
    end
  end

  assign full = (occ == (AW+1)'(FIFO_DEPTH));
  assign pop  = EVT_VALID & EVT_READY;
  assign wr   = push & (~full | pop);

  always_ff @(posedge CLK) begin
    if (wr) mem[wptr] <= {sel_cmd, sel_code};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr    <= '0;
      rptr    <= '0;
      occ     <= '0;
      EVT_OVF <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (wr && !pop)      occ <= occ + 1'b1;
      else if (!wr && pop) occ <= occ - 1'b1;
      if (push && full && !pop) EVT_OVF <= 1'b1;
      else if (CLR_OVF)         EVT_OVF <= 1'b0;
    end
  end

  assign EVT_VALID = (occ != '0);
  assign {EVT_IS_CMD, EVT_CODE} = EVT_VALID ? mem[rptr] : 3'b000;

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
Consumer end of the button-controller interface: takes the live CMD and KEY level groups plus the mode switch and turns them into discrete, debounced press events. Each 4-bit group is synchronised, debounced per bit and edge-detected. Presses are encoded into {is_cmd, index} events and queued in a small FIFO with a valid/ready handshake toward the sale-terminal control FSM.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples needed to accept a level change (10 ms at 50 MHz); must be >= 2
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
KEY_ACTIVE_LOW, 1, 1 = a 0 level on an input bit means pressed
FIFO_DEPTH, 4, event FIFO entries (power of two)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
MODE  in  1  SW[0] level: 1 = CMD group live, 0 = KEY group live
CMD_Reg  in  4  command key levels from the button controller
KEY_Reg  in  4  value key levels from the button controller
EVT_VALID  out  1  FIFO head holds an event
EVT_READY  in  1  consumer accepts head when EVT_VALID && EVT_READY
EVT_IS_CMD  out  1  head event came from the CMD group
EVT_CODE  out  2  head event key index 0..3
EVT_OVF  out  1  sticky: an event was dropped because the FIFO was full
CLR_OVF  in  1  synchronous clear of EVT_OVF

Behaviour:
- Reset: all sync flops and stable states = released, counters 0, pending 0, all keys armed, FIFO empty; EVT_VALID=0, EVT_IS_CMD=0, EVT_CODE=0, EVT_OVF=0. Reset mid-operation discards queued events immediately.
- Sync: 2-FF synchronizer on each of the 8 key bits and on MODE.
- Debounce, per bit: counter counts consecutive synchronized samples that differ from the stable state. The counter resets to 0 on any sample equal to the stable state. Stable state toggles on the edge capturing the DEBOUNCE_CYCLES-th differing sample, and the counter clears.
- Press: stable released->pressed on an armed bit of the live group sets that bit's pending flag. Releases generate no event.
- Inactive group: the upstream controller forces it to 0, which reads as pressed when active-low. Its bits never set pending.
- MODE change: on a synchronized MODE edge, all 8 keys disarm and all pending flags clear. The FIFO is retained. A key re-arms once its stable state is released. A press held across a mode switch therefore yields no event.
- Emitter: each cycle, the lowest pending index is pushed to the FIFO and its flag is cleared. CMD pending has priority over KEY pending; in practice only one group is live. This gives one push per cycle.
- Latency: an input edge held stable yields EVT_VALID high exactly DEBOUNCE_CYCLES+4 rising edges later, with the FIFO empty and no other pending.
- FIFO: registered, first-word fall-through. EVT_IS_CMD and EVT_CODE are valid whenever EVT_VALID=1 and hold until accepted; they read 0 when the FIFO is empty.
- Full FIFO: a push while full with no pop in the same cycle is dropped, and EVT_OVF is set. Push and pop in the same cycle when full: both take effect, no drop.
- CLR_OVF clears EVT_OVF next edge. A simultaneous overflow wins, so EVT_OVF stays 1.
- Pointers wrap modulo FIFO_DEPTH; occupancy count spans 0..FIFO_DEPTH.

Optional Feature:
KEY_AUTOREPEAT_EN:
- Defined: adds parameters REPEAT_DELAY (default 25000000) and REPEAT_PERIOD (default 5000000). A KEY-group key (never CMD) that stays stable-pressed and armed for REPEAT_DELAY cycles after its press sets pending again, and again every REPEAT_PERIOD cycles thereafter. The repeat timer restarts on any release or MODE edge. If several keys are held, the one with the lowest index owns the timer.
- Undefined: no repeat logic; exactly one event per press.

Test Plan:
1. DEBOUNCE_CYCLES=4, MODE=0: KEY_Reg bit2 1->0 and held -> EVT_VALID rises 8 edges later with IS_CMD=0, CODE=2; EVT_READY=1 pops it and no further event follows.
2. Bounce: KEY_Reg bit0 toggles every 2 cycles for 20 cycles, then held 0 -> exactly one event, CODE=0, 8 edges after the last toggle.
3. MODE=1, CMD_Reg bits 1 and 3 pressed in the same cycle -> two events in order CODE=1 then CODE=3, IS_CMD=1, on consecutive cycles.
4. EVT_READY=0, 5 separate presses with FIFO_DEPTH=4 -> 4 events queued, EVT_OVF=1. Pulsing CLR_OVF clears EVT_OVF; draining returns 4 events in press order.
5. Hold KEY bit1 and switch MODE 0->1->0 while holding -> no event. Release and press again -> one event, CODE=1. Inactive-group zeros never produce events.
6. Assert RST_N=0 with 3 events queued and a debounce in progress -> EVT_VALID=0 immediately, all outputs 0. No events after release until a fresh press completes its debounce.
